// File: rtl/serpent_de_iter_pkg.sv
// Shared constants, state encoding, inverse S-boxes and rotate helper for the
// iterative Serpent decryptor.
package serpent_de_iter_pkg;

  localparam int SERPENT_BLK_W  = 128;
  localparam int SERPENT_ROUNDS = 32;
  localparam int SERPENT_WORD_W = 32;
  localparam int RND_W          = $clog2(SERPENT_ROUNDS);
  localparam int KEY_IDX_W      = 6;

  localparam logic [RND_W-1:0]     LAST_ROUND   = RND_W'(SERPENT_ROUNDS - 1);
  localparam logic [KEY_IDX_W-1:0] KEY_IDX_LAST = KEY_IDX_W'(SERPENT_ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Linear-transform rotate/shift amounts, shared by the forward and inverse paths.
  localparam int LT_ROT_0 = 13;
  localparam int LT_ROT_1 = 3;
  localparam int LT_ROT_2 = 1;
  localparam int LT_ROT_3 = 7;
  localparam int LT_ROT_4 = 5;
  localparam int LT_ROT_5 = 22;

  localparam logic [3:0] INV_SBOX [8][16] = '{
    '{4'hD, 4'h3, 4'hB, 4'h0, 4'hA, 4'h6, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hF, 4'h9, 4'h8, 4'h2},
    '{4'h5, 4'h8, 4'h2, 4'hE, 4'hF, 4'h6, 4'hC, 4'h3, 4'hB, 4'h4, 4'h7, 4'h9, 4'h1, 4'hD, 4'hA, 4'h0},
    '{4'hC, 4'h9, 4'hF, 4'h4, 4'hB, 4'hE, 4'h1, 4'h2, 4'h0, 4'h3, 4'h6, 4'hD, 4'h5, 4'h8, 4'hA, 4'h7},
    '{4'h0, 4'h9, 4'hA, 4'h7, 4'hB, 4'hE, 4'h6, 4'hD, 4'h3, 4'h5, 4'hC, 4'h2, 4'h4, 4'h8, 4'hF, 4'h1},
    '{4'h5, 4'h0, 4'h8, 4'h3, 4'hA, 4'h9, 4'h7, 4'hE, 4'h2, 4'hC, 4'hB, 4'h6, 4'h4, 4'hF, 4'hD, 4'h1},
    '{4'h8, 4'hF, 4'h2, 4'h9, 4'h4, 4'h1, 4'hD, 4'hE, 4'hB, 4'h6, 4'h5, 4'h3, 4'h7, 4'hC, 4'hA, 4'h0},
    '{4'hF, 4'hA, 4'h1, 4'hD, 4'h5, 4'h3, 4'h6, 4'h0, 4'h4, 4'h9, 4'hE, 4'h7, 4'h2, 4'hC, 4'h8, 4'hB},
    '{4'h3, 4'h0, 4'h6, 4'hD, 4'h9, 4'hE, 4'hF, 4'h8, 4'h5, 4'hC, 4'hB, 4'h7, 4'hA, 4'h1, 4'h4, 4'h2}
  };

  function automatic logic [SERPENT_WORD_W-1:0] rotr32(input logic [SERPENT_WORD_W-1:0] x,
                                                       input int unsigned n);
    return (x >> n) | (x << (SERPENT_WORD_W - n));
  endfunction

endpackage

// File: rtl/serpent_de_iter_if.sv
// Ciphertext-in / plaintext-out handshakes plus the subkey lookup port of the
// Serpent decryptor; master is the surrounding data path, slave is the core.
interface serpent_de_iter_if;
  import serpent_de_iter_pkg::*;

  logic                     i_valid;
  logic                     o_ready;
  logic [SERPENT_BLK_W-1:0] i_data;
  logic                     o_valid;
  logic                     i_ready;
  logic [SERPENT_BLK_W-1:0] o_data;
  logic [KEY_IDX_W-1:0]     o_key_idx;
  logic [SERPENT_BLK_W-1:0] i_subkey;
  logic                     o_busy;

  modport master (
    output i_valid, i_data, i_ready, i_subkey,
    input  o_ready, o_valid, o_data, o_key_idx, o_busy
  );

  modport slave (
    input  i_valid, i_data, i_ready, i_subkey,
    output o_ready, o_valid, o_data, o_key_idx, o_busy
  );

endinterface

// File: rtl/serpent_de_round.sv
// One combinational inverse Serpent round: optional inverse linear transform,
// bitsliced inverse S-box (round mod 8), then subkey XOR.
module serpent_de_round
  import serpent_de_iter_pkg::*;
(
  input  logic [SERPENT_BLK_W-1:0] i_data,
  input  logic [RND_W-1:0]         i_round,
  input  logic [SERPENT_BLK_W-1:0] i_subkey,
  output logic [SERPENT_BLK_W-1:0] o_data
);

  logic [SERPENT_WORD_W-1:0] w_x0, w_x1, w_x2, w_x3;
  logic [SERPENT_BLK_W-1:0]  w_sb;
  logic [3:0]                w_nib;
  logic [3:0]                w_sub;

  // NOTE: blocking assignments in always_comb form an ordered chain; each line sees the previous line's result.
  always_comb begin
    {w_x3, w_x2, w_x1, w_x0} = i_data;
    if (i_round != LAST_ROUND) begin
      w_x2 = rotr32(w_x2, LT_ROT_5);
      w_x0 = rotr32(w_x0, LT_ROT_4);
      w_x2 = w_x2 ^ w_x3 ^ (w_x1 << LT_ROT_3);
      w_x0 = w_x0 ^ w_x1 ^ w_x3;
      w_x3 = rotr32(w_x3, LT_ROT_3);
      w_x1 = rotr32(w_x1, LT_ROT_2);
      w_x3 = w_x3 ^ w_x2 ^ (w_x0 << LT_ROT_1);
      w_x1 = w_x1 ^ w_x0 ^ w_x2;
      w_x2 = rotr32(w_x2, LT_ROT_1);
      w_x0 = rotr32(w_x0, LT_ROT_0);
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_sb  = '0;
    w_nib = '0;
    w_sub = '0;
    for (int b = 0; b < SERPENT_WORD_W; b++) begin
      w_nib = {w_x3[b], w_x2[b], w_x1[b], w_x0[b]};
      w_sub = INV_SBOX[i_round[2:0]][w_nib];
      w_sb[b]                    = w_sub[0];
      w_sb[SERPENT_WORD_W + b]   = w_sub[1];
      w_sb[2*SERPENT_WORD_W + b] = w_sub[2];
      w_sb[3*SERPENT_WORD_W + b] = w_sub[3];
    end
  end

  assign o_data = w_sb ^ i_subkey;

endmodule

// File: rtl/serpent_de_iter.sv
// Iterative Serpent decryptor: K32 whitening on accept, then 32 inverse rounds
// one per clock, result held in DONE until the consumer takes it.
module serpent_de_iter
  import serpent_de_iter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  serpent_de_iter_if.slave bus
);

  state_e                   r_state;
  logic [SERPENT_BLK_W-1:0] r_x;
  logic [RND_W-1:0]         r_rnd;
  logic                     r_ready;
  logic                     r_valid;
  logic                     r_busy;
  logic [KEY_IDX_W-1:0]     r_key_idx;
  logic [SERPENT_BLK_W-1:0] w_round_out;

  serpent_de_round u_round (
    .i_data   (r_x),
    .i_round  (r_rnd),
    .i_subkey (bus.i_subkey),
    .o_data   (w_round_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_rnd     <= '0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_key_idx <= KEY_IDX_LAST;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.i_valid) begin
            r_x       <= bus.i_data ^ bus.i_subkey;
            r_rnd     <= LAST_ROUND;
            r_state   <= RUN;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
            r_key_idx <= {1'b0, LAST_ROUND};
          end
        end
        RUN: begin
          r_x   <= w_round_out;
          r_rnd <= r_rnd - 1'b1;
          if (r_rnd == '0) begin
            r_state   <= DONE;
            r_valid   <= 1'b1;
            r_key_idx <= KEY_IDX_LAST;
          end else begin
            r_key_idx <= {1'b0, r_rnd - 1'b1};
          end
        end
        DONE: begin
          // New ciphertext is only accepted from IDLE, one cycle after the output handshake.
          if (bus.i_ready) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_ready   <= 1'b1;
          r_valid   <= 1'b0;
          r_busy    <= 1'b0;
          r_key_idx <= KEY_IDX_LAST;
        end
      endcase
    end
  end

  assign bus.o_ready   = r_ready;
  assign bus.o_valid   = r_valid;
  assign bus.o_busy    = r_busy;
  assign bus.o_key_idx = r_key_idx;
  assign bus.o_data    = r_x;

endmodule

// File: tb/tb_serpent_de_iter.sv
// Self-checking bench: plaintexts are encrypted by a forward Serpent model here,
// fed to the decryptor, and results/timing compared with immediate assertions.
module tb_serpent_de_iter;

  localparam int NSLOT = 105;

  localparam int SBOX [8][16] = '{
    '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
    '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
    '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
    '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
    '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
    '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
    '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
    '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
  };

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [127:0] ks_all [0:NSLOT-1][0:32];
  logic [127:0] pt_all [0:NSLOT-1];
  logic [127:0] ct_all [0:NSLOT-1];
  logic [6:0]   ks_sel;

  serpent_de_iter_if bus ();

  serpent_de_iter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  assign bus.i_subkey = ks_all[ks_sel][bus.o_key_idx];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] sbox_fwd(input int box, input logic [127:0] x);
    logic [127:0] y;
    int v;
    int s;
    y = '0;
    for (int b = 0; b < 32; b++) begin
      v = int'({x[96+b], x[64+b], x[32+b], x[b]});
      s = SBOX[box][v];
      y[b] = s[0];
      y[32+b] = s[1];
      y[64+b] = s[2];
      y[96+b] = s[3];
    end
    return y;
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] x);
    logic [31:0] w0, w1, w2, w3;
    {w3, w2, w1, w0} = x;
    w0 = rotl(w0, 13);
    w2 = rotl(w2, 3);
    w1 = w1 ^ w0 ^ w2;
    w3 = w3 ^ w2 ^ (w0 << 3);
    w1 = rotl(w1, 1);
    w3 = rotl(w3, 7);
    w0 = w0 ^ w1 ^ w3;
    w2 = w2 ^ w3 ^ (w1 << 7);
    w0 = rotl(w0, 5);
    w2 = rotl(w2, 22);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [127:0] encrypt(input int slot);
    logic [127:0] x;
    x = pt_all[slot];
    for (int r = 0; r < 32; r++) begin
      x = sbox_fwd(r % 8, x ^ ks_all[slot][r]);
      if (r < 31) x = lt_fwd(x);
      else        x = x ^ ks_all[slot][32];
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a slot's ciphertext, wait (bounded) for the accept, and leave the
  // bench at the negedge of RUN cycle 1 with i_valid dropped.
  task automatic send(input int slot);
    int n;
    n = 0;
    ks_sel = 7'(slot);
    bus.i_data = ct_all[slot];
    bus.i_valid = 1'b1;
    while (!bus.o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 128'(bus.o_ready), 128'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_out(input bit toggle, output int lat);
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      if (toggle) begin
        bus.i_valid = 1'($urandom());
        bus.i_data = rand128();
      end
      @(negedge clk);
      lat++;
    end
    bus.i_valid = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int prev_acc;
    bit saw_valid;
    logic [127:0] held;

    for (int s = 0; s < NSLOT; s++) begin
      for (int r = 0; r <= 32; r++) ks_all[s][r] = (s == 0) ? 128'd0 : rand128();
      pt_all[s] = (s == 0) ? 128'd0 : rand128();
      ct_all[s] = encrypt(s);
    end

    rst = 1'b1;
    ks_sel = '0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 128'(bus.o_ready), 128'd1);
    check("rst_valid", 128'(bus.o_valid), 128'd0);
    check("rst_busy", 128'(bus.o_busy), 128'd0);
    check("rst_data", bus.o_data, 128'd0);
    check("rst_key_idx", 128'(bus.o_key_idx), 128'd32);

    // Zero key schedule, zero plaintext: key index walk and exact latency.
    bus.i_ready = 1'b1;
    ks_sel = 7'd0;
    bus.i_data = ct_all[0];
    bus.i_valid = 1'b1;
    check("zero_accept_ready", 128'(bus.o_ready), 128'd1);
    check("zero_key_idx_32", 128'(bus.o_key_idx), 128'd32);
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check("zero_key_idx", 128'(bus.o_key_idx), 128'(32 - c));
      check("zero_no_valid", 128'(bus.o_valid), 128'd0);
      @(negedge clk);
    end
    check("zero_valid_c33", 128'(bus.o_valid), 128'd1);
    check("zero_data", bus.o_data, 128'd0);

    // 100 random blocks back to back, i_valid held high, i_ready high.
    ks_sel = 7'd1;
    bus.i_data = ct_all[1];
    bus.i_valid = 1'b1;
    prev_acc = 0;
    for (int b = 1; b <= 100; b++) begin
      n = 0;
      while (!bus.o_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_ready", 128'(bus.o_ready), 128'd1);
      if (b > 1) check("b2b_spacing", 128'(cyc - prev_acc), 128'd34);
      prev_acc = cyc;
      @(negedge clk);
      if (b < 100) bus.i_data = ct_all[b+1];
      else         bus.i_valid = 1'b0;
      lat = 1;
      while (!bus.o_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("b2b_latency", 128'(lat), 128'd33);
      check("b2b_data", bus.o_data, pt_all[b]);
      if (b < 100) ks_sel = 7'(b + 1);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;

    // Back-pressure: consumer stalls for 10 cycles after o_valid.
    bus.i_ready = 1'b0;
    send(101);
    wait_out(1'b0, lat);
    check("bp_latency", 128'(lat), 128'd33);
    held = pt_all[101];
    for (int i = 0; i < 10; i++) begin
      check("bp_data_stable", bus.o_data, held);
      check("bp_ready_low", 128'(bus.o_ready), 128'd0);
      check("bp_valid_high", 128'(bus.o_valid), 128'd1);
      @(negedge clk);
    end
    check("bp_valid_at_release", 128'(bus.o_valid), 128'd1);
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after", 128'(bus.o_ready), 128'd1);
    check("bp_valid_after", 128'(bus.o_valid), 128'd0);
    check("bp_busy_after", 128'(bus.o_busy), 128'd0);

    // Reset pulse at RUN cycle 15 discards the block.
    send(102);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 128'(bus.o_ready), 128'd1);
    check("mid_rst_valid", 128'(bus.o_valid), 128'd0);
    check("mid_rst_busy", 128'(bus.o_busy), 128'd0);
    check("mid_rst_data", bus.o_data, 128'd0);
    check("mid_rst_key_idx", 128'(bus.o_key_idx), 128'd32);
    saw_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.o_valid) saw_valid = 1'b1;
      @(negedge clk);
    end
    check("mid_rst_no_output", 128'(saw_valid), 128'd0);

    send(103);
    wait_out(1'b0, lat);
    check("post_rst_latency", 128'(lat), 128'd33);
    check("post_rst_data", bus.o_data, pt_all[103]);
    @(negedge clk);

    // i_valid and i_data churn while the block is in flight.
    send(104);
    wait_out(1'b1, lat);
    check("toggle_latency", 128'(lat), 128'd33);
    check("toggle_data", bus.o_data, pt_all[104]);
    @(negedge clk);
    check("toggle_ready_after", 128'(bus.o_ready), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
